seg_scan_ctrl: RTL and testbench
================================

// Module: seg_scan_ctrl
// PURPOSE
//  Time-multiplexed scan controller for a DIGITS-wide common-select 7-segment display.
//  - Shares one seg_display decoder across all digits.
//  - Sequences digit select with a programmable dead time between digits to prevent ghosting.
//  - Double-buffers the display value so updates only take effect at frame boundaries.
//  - Sits between the value producer (counter, UART, etc.) and the board's segment and select pins.
// PARAMETERS
//  DIGITS  4      number of digits scanned (>=2)
//  DIV     50000  clocks per digit slot (> BLANK+1)
//  BLANK   16     dead-time clocks at start of each slot, all selects off (>=1)
// PORTS
//  i_clk      in   1          system clock
//  i_rst      in   1          synchronous reset, active-high
//  i_data     in   4*DIGITS   hex nibbles; nibble k drives digit k (digit 0 = LSB, rightmost)
//  i_dp       in   DIGITS     decimal point per digit
//  i_load     in   1          capture i_data/i_dp into pending buffer this cycle
//  o_pending  out  1          pending buffer holds data not yet shown
//  o_frame    out  1          1-cycle pulse at each frame boundary
//  o_an       out  DIGITS     one-hot digit select, active-high
//  o_seg      out  7          segments from seg_display (same bit order/polarity); 0 = blank
//  o_dp       out  1          decimal point of the selected digit
// BEHAVIOUR
//  - One clock domain: i_clk. Reset is synchronous, active-high (i_rst).
//  - Reset values:
//    - r_div=0, r_idx=0, shadow=0, pending buffer=0.
//    - o_pending=0, o_frame=0, o_an=0, o_seg=0, o_dp=0.
//  - Prescaler r_div counts 0..DIV-1, then wraps to 0.
//    - On wrap, r_idx advances 0..DIGITS-1, then wraps to 0.
//  - Frame boundary: cycle where r_idx==DIGITS-1 and r_div==DIV-1.
//    - o_frame=1 on the following cycle, for exactly 1 cycle.
//  - Select and segment outputs are registered, 1-cycle latency from (r_div, r_idx).
//    - r_div<BLANK: o_an=0, o_seg=0, o_dp=0.
//    - Otherwise: o_an=1<<r_idx, o_seg=decode(shadow nibble r_idx), o_dp=shadow dp[r_idx].
//  - Load handshake:
//    - i_load=1: pending buffer takes i_data/i_dp; o_pending=1 next cycle.
//    - No back-pressure. Multiple loads within one frame: last one wins.
//  - At a frame boundary with o_pending=1: shadow takes the pending buffer, and o_pending clears.
//  - i_load coincident with a boundary:
//    - Shadow takes the old pending contents, only if pending was set.
//    - The buffer takes the new data; o_pending stays/becomes 1.
//  - Shadow never changes mid-frame, so the displayed value is always frame-consistent.
//  - i_rst mid-frame: all state returns to reset values next cycle; scan restarts at digit 0, slot start.
// CONFIGURATION
//  - LEADING_ZERO_BLANK_EN defined:
//    - Digit k (k>=1) is suppressed when shadow nibbles k..DIGITS-1 are all 0 and dp[k..DIGITS-1] are all 0.
//    - A suppressed digit keeps o_an=0, o_seg=0 for its whole slot; slot timing is unchanged.
//    - Digit 0 is never suppressed.
//  - LEADING_ZERO_BLANK_EN undefined: every digit is shown; suppression logic is not compiled.
// STRUCTURE
//  - Package seg_pkg holds shared constants: SEG_BLANK = 7'b0, and nibble width NIB_W = 4.
//  - Sub-module: one seg_display instance, fed the muxed shadow nibble and dp.
//  - Widths: r_div $clog2(DIV); r_idx $clog2(DIGITS).
// TESTING  (DIGITS=4, DIV=8, BLANK=2)
//  1. Reset held 3 cycles, then released.
//     -> all outputs 0 during reset.
//     -> o_an=0001 for cycles 3..8, 0 for 2 cycles, then 0010.
//     -> o_frame pulses every 32 cycles.
//  2. i_load with i_data=16'h1234, i_dp=4'b0100.
//     -> o_pending=1 until the next boundary.
//     -> next frame shows digits 0..3 as 4,3,2,1, with o_dp=1 only while o_an=0100.
//  3. Two loads in one frame, 16'hAAAA then 16'h5555.
//     -> old value shown until o_frame; then 5555 is shown; AAAA never appears.
//  4. i_load 16'h00FF on the boundary cycle, pending=0 beforehand.
//     -> shadow unchanged that frame; o_pending=1.
//     -> 00FF is shown from the following frame.
//  5. i_rst pulsed while o_an=0100 with 16'h1234 displayed.
//     -> next cycle all outputs 0 and shadow=0.
//     -> scan resumes at digit 0 showing 0.
//  6. LEADING_ZERO_BLANK_EN defined.
//     -> 16'h0040: digits 3,2 stay dark; digits 1,0 show 4,0.
//     -> 16'h0000: only digit 0 shows 0.
//     -> 16'h0000 with dp=4'b1000: all four digits shown.

Source files
------------

// File: rtl/seg_scan_ctrl_pkg.sv
// Shared constants for the 7-segment scan controller.
// Package seg_pkg: blank pattern and nibble width.
package seg_pkg;
  localparam logic [6:0] SEG_BLANK = 7'b0;
  localparam int NIB_W = 4;
endpackage

// File: rtl/seg_scan_ctrl_if.sv
// Producer-side bus of the scan controller.
// master = value producer, slave = seg_scan_ctrl.
interface seg_scan_ctrl_if #(
  parameter int DIGITS = 4
);
  logic [4*DIGITS-1:0] i_data;
  logic [DIGITS-1:0]   i_dp;
  logic                i_load;
  logic                o_pending;
  logic                o_frame;
  logic [DIGITS-1:0]   o_an;
  logic [6:0]          o_seg;
  logic                o_dp;

  modport master (
    output i_data, i_dp, i_load,
    input  o_pending, o_frame, o_an, o_seg, o_dp
  );

  modport slave (
    input  i_data, i_dp, i_load,
    output o_pending, o_frame, o_an, o_seg, o_dp
  );
endinterface

// File: rtl/seg_scan_ctrl_display.sv
// Hex nibble to 7-segment decoder, seg = {g,f,e,d,c,b,a}.
// Active-high segments; dp passes straight through.
module seg_display (
  input  logic [3:0] nib,
  input  logic       dp_in,
  output logic [6:0] seg,
  output logic       dp_out
);
  // combinational hex decode
  always_comb begin
    seg = 7'h00;
    unique case (nib)
      4'h0: seg = 7'h3F;
      4'h1: seg = 7'h06;
      4'h2: seg = 7'h5B;
      4'h3: seg = 7'h4F;
      4'h4: seg = 7'h66;
      4'h5: seg = 7'h6D;
      4'h6: seg = 7'h7D;
      4'h7: seg = 7'h07;
      4'h8: seg = 7'h7F;
      4'h9: seg = 7'h6F;
      4'hA: seg = 7'h77;
      4'hB: seg = 7'h7C;
      4'hC: seg = 7'h39;
      4'hD: seg = 7'h5E;
      4'hE: seg = 7'h79;
      4'hF: seg = 7'h71;
      default: seg = 7'h00;
    endcase
  end

  assign dp_out = dp_in;
endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed 7-segment scan controller with frame-synchronous double buffer.
// Optional LEADING_ZERO_BLANK_EN hides leading zero digits.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter int DIV    = 50000,
  parameter int BLANK  = 16
) (
  input  logic           i_clk,
  input  logic           i_rst,
  seg_scan_ctrl_if.slave bus
);
  localparam int DW = $clog2(DIV);
  localparam int IW = $clog2(DIGITS);
  localparam int BW = NIB_W * DIGITS;
  localparam logic [DW-1:0] DIV_LAST  = DW'(DIV - 1);
  localparam logic [DW-1:0] BLANK_END = DW'(BLANK);
  localparam logic [IW-1:0] IDX_LAST  = IW'(DIGITS - 1);

  logic [DW-1:0]     r_div;
  logic [IW-1:0]     r_idx;
  logic [BW-1:0]     pend_data;
  logic [DIGITS-1:0] pend_dp;
  logic              pending;
  logic [BW-1:0]     shadow_data;
  logic [DIGITS-1:0] shadow_dp;
  logic              frame_q;
  logic [DIGITS-1:0] an_q;
  logic [6:0]        seg_q;
  logic              dp_q;

  logic              div_wrap;
  logic              boundary;
  logic [NIB_W-1:0]  nib;
  logic              nib_dp;
  logic [6:0]        seg_w;
  logic              dp_w;
  logic              sup;

  assign div_wrap = (r_div == DIV_LAST);
  assign boundary = div_wrap && (r_idx == IDX_LAST);
  assign nib      = shadow_data[r_idx*NIB_W +: NIB_W];
  assign nib_dp   = shadow_dp[r_idx];

  seg_display u_dec (
    .nib    (nib),
    .dp_in  (nib_dp),
    .seg    (seg_w),
    .dp_out (dp_w)
  );

`ifdef LEADING_ZERO_BLANK_EN
  logic [DIGITS-1:0] lz;
  logic              lz_run;

  // mark digits above the most significant nonzero nibble/dp
  always_comb begin
    lz     = '0;
    lz_run = 1'b1;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      lz_run = lz_run
             & (shadow_data[k*NIB_W +: NIB_W] == '0)
             & ~shadow_dp[k];
      if (k != 0) lz[k] = lz_run;
    end
  end

  assign sup = lz[r_idx];
`else
  assign sup = 1'b0;
`endif

  // slot prescaler and digit index
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_div <= '0;
      r_idx <= '0;
    end else if (div_wrap) begin
      r_div <= '0;
      r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
    end else begin
      r_div <= r_div + 1'b1;
    end
  end

  // pending buffer and frame-synchronous shadow
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pend_data   <= '0;
      pend_dp     <= '0;
      pending     <= 1'b0;
      shadow_data <= '0;
      shadow_dp   <= '0;
    end else begin
      if (boundary && pending) begin
        shadow_data <= pend_data;
        shadow_dp   <= pend_dp;
      end
      if (bus.i_load) begin
        pend_data <= bus.i_data;
        pend_dp   <= bus.i_dp;
        pending   <= 1'b1;
      end else if (boundary) begin
        pending   <= 1'b0;
      end
    end
  end

  // registered select/segment outputs with dead time
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      frame_q <= 1'b0;
      an_q    <= '0;
      seg_q   <= SEG_BLANK;
      dp_q    <= 1'b0;
    end else begin
      frame_q <= boundary;
      if (r_div < BLANK_END || sup) begin
        an_q  <= '0;
        seg_q <= SEG_BLANK;
        dp_q  <= 1'b0;
      end else begin
        an_q  <= DIGITS'(1) << r_idx;
        seg_q <= seg_w;
        dp_q  <= dp_w;
      end
    end
  end

  assign bus.o_pending = pending;
  assign bus.o_frame   = frame_q;
  assign bus.o_an      = an_q;
  assign bus.o_seg     = seg_q;
  assign bus.o_dp      = dp_q;
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl (DIGITS=4, DIV=8, BLANK=2).
// Leading-zero cases run only with LEADING_ZERO_BLANK_EN.
module tb_seg_scan_ctrl;
  localparam logic [6:0] S0 = 7'h3F;
  localparam logic [6:0] S1 = 7'h06;
  localparam logic [6:0] S2 = 7'h5B;
  localparam logic [6:0] S3 = 7'h4F;
  localparam logic [6:0] S4 = 7'h66;
  localparam logic [6:0] S5 = 7'h6D;
  localparam logic [6:0] SF = 7'h71;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_pass  = 0;
  int   n_total = 0;
  int   k_last  = -1;

  seg_scan_ctrl_if #(.DIGITS(4)) bus ();

  seg_scan_ctrl #(
    .DIGITS (4),
    .DIV    (8),
    .BLANK  (2)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask

  task automatic goto(input int k);
    while (k_last < k) begin
      @(negedge clk);
      k_last++;
    end
  endtask

  task automatic do_load(input logic [15:0] d,
                         input logic [3:0] dp,
                         input int e);
    goto(e - 1);
    bus.i_data = d;
    bus.i_dp   = dp;
    bus.i_load = 1'b1;
    goto(e);
    bus.i_load = 1'b0;
  endtask

  task automatic chk_out(input string tag,
                         input logic [3:0] an,
                         input logic [6:0] seg,
                         input logic dp);
    chk({tag, ".an"},  32'(bus.o_an),  32'(an));
    chk({tag, ".seg"}, 32'(bus.o_seg), 32'(seg));
    chk({tag, ".dp"},  32'(bus.o_dp),  32'(dp));
  endtask

  initial begin
    bus.i_data = '0;
    bus.i_dp   = '0;
    bus.i_load = 1'b0;

    // 1: reset and bare scan timing
    repeat (3) @(negedge clk);
    chk_out("rst", 4'b0000, 7'h00, 1'b0);
    chk("rst.frame", 32'(bus.o_frame), 0);
    chk("rst.pend", 32'(bus.o_pending), 0);
    rst = 1'b0;
    k_last = -1;
    goto(0);   chk("k0.an", 32'(bus.o_an), 0);
    goto(2);   chk_out("k2", 4'b0001, S0, 1'b0);
    goto(7);   chk("k7.an", 32'(bus.o_an), 32'h1);
    goto(8);   chk("k8.an", 32'(bus.o_an), 0);
    goto(9);   chk("k9.an", 32'(bus.o_an), 0);
    goto(10);  chk("k10.an", 32'(bus.o_an), 32'h2);
    goto(30);  chk("k30.frame", 32'(bus.o_frame), 0);
    goto(31);  chk("k31.frame", 32'(bus.o_frame), 1);
    goto(32);  chk("k32.frame", 32'(bus.o_frame), 0);
    goto(63);  chk("k63.frame", 32'(bus.o_frame), 1);

    // 2: single load, shown from next frame
    do_load(16'h1234, 4'b0100, 66);
    chk("t2.pend", 32'(bus.o_pending), 1);
    goto(90);  chk_out("t2.old", 4'b1000, S0, 1'b0);
    goto(94);  chk("t2.pend94", 32'(bus.o_pending), 1);
    goto(95);
    chk("t2.pend95", 32'(bus.o_pending), 0);
    chk("t2.frame", 32'(bus.o_frame), 1);
    goto(98);  chk_out("t2.d0", 4'b0001, S4, 1'b0);
    goto(106); chk_out("t2.d1", 4'b0010, S3, 1'b0);
    goto(114); chk_out("t2.d2", 4'b0100, S2, 1'b1);
    goto(122); chk_out("t2.d3", 4'b1000, S1, 1'b0);

    // 3: two loads in a frame, last one wins
    do_load(16'hAAAA, 4'b0000, 130);
    do_load(16'h5555, 4'b0000, 140);
    goto(150); chk_out("t3.old2", 4'b0100, S2, 1'b1);
    goto(158); chk_out("t3.old3", 4'b1000, S1, 1'b0);
    goto(162); chk_out("t3.d0", 4'b0001, S5, 1'b0);
    goto(170); chk_out("t3.d1", 4'b0010, S5, 1'b0);

    // 4: load on the boundary cycle with nothing pending
    do_load(16'h00FF, 4'b0000, 191);
    chk("t4.pend", 32'(bus.o_pending), 1);
    chk("t4.frame", 32'(bus.o_frame), 1);
    goto(194); chk_out("t4.keep0", 4'b0001, S5, 1'b0);
    goto(218); chk_out("t4.keep3", 4'b1000, S5, 1'b0);
    goto(222); chk("t4.pend222", 32'(bus.o_pending), 1);
    goto(223); chk("t4.pend223", 32'(bus.o_pending), 0);
    goto(226); chk_out("t4.d0", 4'b0001, SF, 1'b0);
    goto(234); chk_out("t4.d1", 4'b0010, SF, 1'b0);
    goto(242); chk_out("t4.d2", 4'b0100, S0, 1'b0);

    // 5: reset while digit 2 of 1234 is lit
    do_load(16'h1234, 4'b0100, 250);
    goto(274); chk_out("t5.pre", 4'b0100, S2, 1'b1);
    goto(275);
    rst = 1'b1;
    goto(276);
    chk_out("t5.rst", 4'b0000, 7'h00, 1'b0);
    chk("t5.frame", 32'(bus.o_frame), 0);
    chk("t5.pend", 32'(bus.o_pending), 0);
    rst = 1'b0;
    k_last = -1;
    goto(2);   chk_out("t5.d0", 4'b0001, S0, 1'b0);
    goto(18);  chk_out("t5.d2", 4'b0100, S0, 1'b0);

`ifdef LEADING_ZERO_BLANK_EN
    // 6: leading-zero suppression
    do_load(16'h0040, 4'b0000, 20);
    goto(34);  chk_out("t6a.d0", 4'b0001, S0, 1'b0);
    goto(42);  chk_out("t6a.d1", 4'b0010, S4, 1'b0);
    goto(50);  chk_out("t6a.d2", 4'b0000, 7'h00, 1'b0);
    goto(58);  chk_out("t6a.d3", 4'b0000, 7'h00, 1'b0);
    do_load(16'h0000, 4'b0000, 60);
    goto(66);  chk_out("t6b.d0", 4'b0001, S0, 1'b0);
    goto(74);  chk_out("t6b.d1", 4'b0000, 7'h00, 1'b0);
    do_load(16'h0000, 4'b1000, 80);
    goto(98);  chk_out("t6c.d0", 4'b0001, S0, 1'b0);
    goto(106); chk_out("t6c.d1", 4'b0010, S0, 1'b0);
    goto(114); chk_out("t6c.d2", 4'b0100, S0, 1'b0);
    goto(122); chk_out("t6c.d3", 4'b1000, S0, 1'b1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
